// File: rtl/regs_mp.sv
// Multi-port register file: 2^a words of n bits, two registered read ports, one write port, %0 reads zero.
// A sequential clear engine zeroes storage after reset. Optional macro REGS_BYPASS_EN enables write-first forwarding.
module regs_mp #(
  parameter int n = 8,
  parameter int a = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         w,
  input  logic [a-1:0] Waddr,
  input  logic [n-1:0] Wdata,
  input  logic [a-1:0] Raddr1,
  output logic [n-1:0] Rdata1,
  input  logic [a-1:0] Raddr2,
  output logic [n-1:0] Rdata2,
  output logic         busy
);

  localparam int depth = 2 ** a;
  localparam logic [a-1:0] last_addr = '1;
  localparam logic [a-1:0] first_addr = a'(1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t       state;
  state_t       state_next;
  logic [a-1:0] ptr;
  logic [n-1:0] mem [depth];
  logic         mem_we;
  logic [a-1:0] mem_addr;
  logic [n-1:0] mem_data;
  logic [n-1:0] read1;
  logic [n-1:0] read2;

  // The pointer parks on the last address once the walk completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= first_addr;
    end else begin
      state <= state_next;
      if (state == CLEAR && ptr != last_addr)
        ptr <= ptr + a'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_addr   = Waddr;
    mem_data   = Wdata;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = ptr;
        mem_data = '0;
        if (ptr == last_addr)
          state_next = READY;
      end
      READY: begin
        if (w && Waddr != '0)
          mem_we = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign busy = (state == CLEAR);

  // Storage has no reset so it can map onto MLAB/sync RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_data;
  end

  always_comb begin
    read1 = (Raddr1 == '0) ? '0 : mem[Raddr1];
    read2 = (Raddr2 == '0) ? '0 : mem[Raddr2];
`ifdef REGS_BYPASS_EN
    if (state == READY && mem_we && Waddr == Raddr1)
      read1 = Wdata;
    if (state == READY && mem_we && Waddr == Raddr2)
      read2 = Wdata;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) begin
      Rdata1 <= '0;
      Rdata2 <= '0;
    end else begin
      Rdata1 <= read1;
      Rdata2 <= read2;
    end
  end

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp (n=8, a=5) using a behavioural model and an expectation queue.
module tb_regs_mp;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w = 1'b0;
  logic [4:0] Waddr = '0;
  logic [7:0] Wdata = '0;
  logic [4:0] Raddr1 = '0;
  logic [4:0] Raddr2 = '0;
  logic [7:0] Rdata1;
  logic [7:0] Rdata2;
  logic       busy;

  typedef struct {
    logic [7:0] r1;
    logic [7:0] r2;
    logic       b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [32];
  int         clear_left = 31;
  int         check_count = 0;
  int         pass_count = 0;

  regs_mp #(.n(8), .a(5)) dut (
    .clk(clk), .reset(reset), .w(w), .Waddr(Waddr), .Wdata(Wdata),
    .Raddr1(Raddr1), .Rdata1(Rdata1), .Raddr2(Raddr2), .Rdata2(Rdata2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic wv, input logic [4:0] wa,
                               input logic [7:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    exp_t got;
    reset = rst; w = wv; Waddr = wa; Wdata = wd; Raddr1 = ra1; Raddr2 = ra2;
    if (rst) begin
      clear_left = 31;
      for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
      e.r1 = 8'h00; e.r2 = 8'h00; e.b = 1'b1;
    end else if (clear_left > 0) begin
      clear_left--;
      e.r1 = 8'h00; e.r2 = 8'h00; e.b = (clear_left > 0);
    end else begin
      e.r1 = (ra1 == 0) ? 8'h00 : model_mem[ra1];
      e.r2 = (ra2 == 0) ? 8'h00 : model_mem[ra2];
`ifdef REGS_BYPASS_EN
      if (wv && wa != 0 && wa == ra1) e.r1 = wd;
      if (wv && wa != 0 && wa == ra2) e.r2 = wd;
`endif
      if (wv && wa != 0) model_mem[wa] = wd;
      e.b = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    checkOutput({tag, ".rdata1"}, {24'h0, Rdata1}, {24'h0, got.r1});
    checkOutput({tag, ".rdata2"}, {24'h0, Rdata2}, {24'h0, got.r2});
    checkOutput({tag, ".busy"}, {31'h0, busy}, {31'h0, got.b});
  endtask

  task automatic idle(input string tag, input logic [4:0] ra1, input logic [4:0] ra2);
    applyStimulus(tag, 1'b0, 1'b0, 5'd0, 8'h00, ra1, ra2);
  endtask

  task automatic measureBusy(input string tag);
    int high = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      idle(tag, 5'd0, 5'd0);
      high++;
    end
    checkOutput({tag, ".busy_cycles"}, high, 31);
  endtask

  initial begin
    @(negedge clk);
    // Test 1: two-cycle reset, then a full clear walk of exactly 31 busy cycles.
    applyStimulus("reset0", 1'b1, 1'b0, 5'd0, 8'h00, 5'd3, 5'd4);
    applyStimulus("reset1", 1'b1, 1'b0, 5'd0, 8'h00, 5'd3, 5'd4);
    measureBusy("clear");
    for (int i = 0; i < 32; i++)
      idle("zero_scan", 5'(i), 5'(31 - i));

    // Test 2: basic write then read on each port.
    applyStimulus("wr1", 1'b0, 1'b1, 5'd1, 8'd13, 5'd0, 5'd0);
    idle("rd1", 5'd1, 5'd0);
    applyStimulus("wr2", 1'b0, 1'b1, 5'd2, 8'h88, 5'd0, 5'd0);
    idle("rd2", 5'd1, 5'd2);
    idle("rd_same", 5'd2, 5'd2);

    // Test 3: writes to %0 are discarded.
    applyStimulus("wr0", 1'b0, 1'b1, 5'd0, 8'hFF, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) idle("rd0", 5'd0, 5'd0);

    // Test 4: read-during-write on the same address.
    applyStimulus("wr5a", 1'b0, 1'b1, 5'd5, 8'h11, 5'd0, 5'd0);
    applyStimulus("rdw5", 1'b0, 1'b1, 5'd5, 8'h22, 5'd5, 5'd1);
    idle("rd5", 5'd5, 5'd5);
    applyStimulus("rdw_p2", 1'b0, 1'b1, 5'd31, 8'hA5, 5'd2, 5'd31);
    idle("rd31", 5'd31, 5'd1);

    // Test 6 setup: register 20 holds data before a reset.
    applyStimulus("wr20", 1'b0, 1'b1, 5'd20, 8'h3C, 5'd0, 5'd0);
    idle("rd20_pre", 5'd20, 5'd0);

    // Test 5: writes during the clear are ignored.
    applyStimulus("reset2", 1'b1, 1'b0, 5'd0, 8'h00, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++)
      applyStimulus("wr_busy", 1'b0, 1'b1, 5'd7, 8'h5A, 5'd7, 5'd20);

    // Test 6: reset mid-clear restarts a fresh 31-cycle walk.
    applyStimulus("reset3", 1'b1, 1'b1, 5'd7, 8'h5A, 5'd7, 5'd20);
    measureBusy("reclear");
    idle("rd7_20", 5'd7, 5'd20);
    idle("rd1_after", 5'd1, 5'd5);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
